// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: turns core load/store requests into byte-enabled
// data-memory accesses and aligns/extends the returned load data.
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [1:0] off;
        logic [2:0] size;
        logic       we;
    } rsp_t;

    logic [1:0]  state_q, state_d;
    rsp_t        rsp_q;
    logic        size_ok, align_ok, legal, in_idle, issue, accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;

    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
        case (core_size_i)
            3'd0, 3'd4: begin size_ok = 1'b1; align_ok = 1'b1; end
            3'd1, 3'd5: begin size_ok = 1'b1; align_ok = ~core_addr_i[0]; end
            3'd2:       begin size_ok = 1'b1; align_ok = (core_addr_i[1:0] == 2'b00); end
            default:    ;
        endcase
        // unsigned sizes have no store form
        if (core_we_i && core_size_i[2]) size_ok = 1'b0;
    end

    assign legal        = size_ok & align_ok;
    assign in_idle      = (state_q == S_IDLE);
    assign issue        = in_idle & core_req_i & legal;
    assign core_fault_o = in_idle & core_req_i & ~legal;
    assign mem_req_o    = issue | (state_q == S_REQ);
    assign core_stall_o = mem_req_o;
    assign mem_we_o     = mem_req_o & core_we_i;
    assign mem_addr_o   = core_addr_i;
    assign accept       = mem_req_o & mem_ready_i;

    always_comb begin
        case (core_size_i[1:0])
            2'd0: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
                mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: begin
                mem_be_o = 4'b1111;
                mem_wd_o = core_wd_i;
            end
        endcase
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  if (issue) state_d = mem_ready_i ? S_RESP : S_REQ;
            S_REQ:   state_d = mem_ready_i ? S_RESP : S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_q.off  <= core_addr_i[1:0];
                rsp_q.size <= core_size_i;
                rsp_q.we   <= core_we_i;
            end
        end
    end

    always_comb begin
        case (rsp_q.off)
            2'd0:    byte_sel = mem_rd_i[7:0];
            2'd1:    byte_sel = mem_rd_i[15:8];
            2'd2:    byte_sel = mem_rd_i[23:16];
            default: byte_sel = mem_rd_i[31:24];
        endcase
        half_sel = rsp_q.off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        // size[2] marks the zero-extending variants
        case (rsp_q.size[1:0])
            2'd0:    ext = {{24{~rsp_q.size[2] & byte_sel[7]}}, byte_sel};
            2'd1:    ext = {{16{~rsp_q.size[2] & half_sel[15]}}, half_sel};
            default: ext = mem_rd_i;
        endcase
    end

    assign core_rd_o = (state_q == S_RESP && !rsp_q.we) ? ext : 32'h0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: stimulus pushes expected accesses, a
// monitor pops them on each memory acceptance and checks the response cycle.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] mem_rd_i = 32'hDEAD_DEAD;
    logic        mem_ready_i = 1'b0;
    logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
    logic        core_stall_o, core_fault_o, mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;

    riscv_lsu dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .core_fault_o(core_fault_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: acceptance pops the next expected access, the cycle after is the response
    always @(negedge clk_i) begin
        if (pend) begin
            chk("rsp_rd", core_rd_o, pend_rd);
            pend = 1'b0;
        end
        if (!rst_i && mem_req_o && mem_ready_i) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got request at addr %h, expected none", mem_addr_o);
            end else begin
                mon_e = q.pop_front();
                chk("req_be", {28'h0, mem_be_o}, {28'h0, mon_e.be});
                chk("req_we", {31'h0, mem_we_o}, {31'h0, mon_e.we});
                chk("req_addr", mem_addr_o, mon_e.addr);
                if (mon_e.we) chk("req_wd", mem_wd_o, mon_e.wd);
                pend    = 1'b1;
                pend_rd = mon_e.rd;
            end
        end
    end

    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                          input logic [3:0] be, input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        exp_t e;
        e.we = we; e.be = be; e.addr = addr; e.wd = exp_wd; e.rd = exp_rd;
        q.push_back(e);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = (waits == 0);
        mem_rd_i    = 32'hDEAD_DEAD;
        for (int c = 0; c <= waits; c++) begin
            @(negedge clk_i);
            chk("stall_busy", {31'h0, core_stall_o}, 32'h1);
            chk("req_busy", {31'h0, mem_req_o}, 32'h1);
            chk("fault_busy", {31'h0, core_fault_o}, 32'h0);
            chk("addr_hold", mem_addr_o, addr);
            if (we) chk("wd_hold", mem_wd_o, exp_wd);
            @(posedge clk_i); #1;
            mem_ready_i = (c + 1 == waits);
        end
        mem_rd_i = rdata;
        @(negedge clk_i);
        chk("stall_resp", {31'h0, core_stall_o}, 32'h0);
        chk("req_resp", {31'h0, mem_req_o}, 32'h0);
        chk("fault_resp", {31'h0, core_fault_o}, 32'h0);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        mem_rd_i   = 32'hDEAD_DEAD;
    endtask

    task automatic fault(input string name, input logic we, input logic [2:0] size,
                         input logic [31:0] addr);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = 32'h5555_5555;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        chk({name, "_fault"}, {31'h0, core_fault_o}, 32'h1);
        chk({name, "_req"}, {31'h0, mem_req_o}, 32'h0);
        chk({name, "_stall"}, {31'h0, core_stall_o}, 32'h0);
        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_idle_req"}, {31'h0, mem_req_o}, 32'h0);
        chk({name, "_idle_fault"}, {31'h0, core_fault_o}, 32'h0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_stall", {31'h0, core_stall_o}, 32'h0);
        chk("rst_fault", {31'h0, core_fault_o}, 32'h0);
        chk("rst_rd", core_rd_o, 32'h0);
        @(posedge clk_i); #1;

        // we, size, addr, wd, rdata, waits, be, exp_wd, exp_rd
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        access(1'b0, 3'd5, 32'h102, 32'h0, 32'hBEEF_0000, 0, 4'b1100, 32'h0, 32'h0000_BEEF);
        access(1'b0, 3'd2, 32'h100, 32'h0, 32'hBEEF_0000, 0, 4'b1111, 32'h0, 32'hBEEF_0000);
        access(1'b1, 3'd0, 32'h001, 32'hFFFF_FFAB, 32'h0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
        access(1'b1, 3'd1, 32'h002, 32'hAAAA_1234, 32'h0, 0, 4'b1100, 32'h1234_1234, 32'h0);
        access(1'b1, 3'd2, 32'h200, 32'hCAFE_F00D, 32'h0, 3, 4'b1111, 32'hCAFE_F00D, 32'h0);
        access(1'b0, 3'd1, 32'h000, 32'h0, 32'h1234_8001, 3, 4'b0011, 32'h0, 32'hFFFF_8001);
        access(1'b0, 3'd4, 32'h002, 32'h0, 32'h00C3_0000, 1, 4'b0100, 32'h0, 32'h0000_00C3);

        fault("lw_mis", 1'b0, 3'd2, 32'h102);
        fault("size3", 1'b0, 3'd3, 32'h000);
        fault("sbu", 1'b1, 3'd4, 32'h000);
        fault("lh_odd", 1'b0, 3'd1, 32'h003);

        // reset while a load waits in REQ
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h300;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("abort_stall", {31'h0, core_stall_o}, 32'h1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        @(negedge clk_i);
        chk("abort_req", {31'h0, mem_req_o}, 32'h0);
        chk("abort_stall_lo", {31'h0, core_stall_o}, 32'h0);
        chk("abort_rd", core_rd_o, 32'h0);
        @(posedge clk_i); #1;
        access(1'b0, 3'd0, 32'h001, 32'h0, 32'h0000_7F00, 0, 4'b0010, 32'h0, 32'h0000_007F);

        repeat (2) @(negedge clk_i);
        chk("queue_empty", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
